// File: rtl/sync_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sync_tx_pkg
// Brief    : Shared types and constants for the sync-framed serial transmitter.
// Revision : 1.0
// ============================================================================
package sync_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        PAR  = 2'd3
    } tx_state_t;

    localparam logic [3:0] SYNC_PATTERN = 4'b1101;
    localparam int         SYNC_BITS    = 4;

    // Payload is zero-extended into the word, which leaves even parity unchanged.
    function automatic logic even_parity(input logic [31:0] word);
        return ^word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/flex_counter.sv
`default_nettype none
// ============================================================================
// Module   : flex_counter
// Brief    : Up-counter that wraps to zero after reaching rollover_val-1.
// Revision : 1.0
// ============================================================================
module flex_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [WIDTH-1:0] rollover_val,
    output logic             rollover_flag
);

    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    // Flags the final count; the wrap itself happens only when enabled.
    assign rollover_flag = (r_count == (rollover_val - c_one));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (count_enable) begin
            if (rollover_flag) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + c_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sync_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : sync_frame_tx
// Brief    : Frames each accepted word as header 1101, LSB-first payload and
//            optional even parity onto a registered serial line.
// Revision : 1.0
// ============================================================================
module sync_frame_tx
    import sync_tx_pkg::*;
#(
    parameter int   DATA_BITS  = 8,
    parameter int   BIT_CYCLES = 1,
    parameter int   PARITY_EN  = 1,
    parameter logic IDLE_VALUE = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 serial_out,
    output logic                 busy,
    output logic                 frame_done
);

    localparam logic [4:0] c_bit_roll = 5'(BIT_CYCLES);

    tx_state_t              r_state;
    tx_state_t              w_next_state;
    logic [DATA_BITS-1:0]   r_shift;
    logic [2:0]             r_hdr;
    logic                   r_parity;
    logic [5:0]             w_idx_roll;
    logic                   w_timer_flag;
    logic                   w_idx_flag;
    logic                   w_bit_wrap;
    logic                   w_last_wrap;
    logic                   w_accept;
    logic                   w_state_change;

    assign tx_ready       = (r_state == IDLE);
    assign busy           = (r_state != IDLE);
    assign w_accept       = tx_valid && (r_state == IDLE);
    assign w_bit_wrap     = busy && w_timer_flag;
    assign w_last_wrap    = w_bit_wrap && w_idx_flag;
    assign w_state_change = (w_next_state != r_state);

    always_comb begin
        w_idx_roll = 6'd1;
        case (r_state)
            SYNC:    w_idx_roll = 6'(SYNC_BITS);
            DATA:    w_idx_roll = 6'(DATA_BITS);
            default: w_idx_roll = 6'd1;
        endcase
    end

    flex_counter #(
        .WIDTH (5)
    ) u_bit_timer (
        .clk           (clk),
        .rst           (rst),
        .clear         (w_state_change),
        .count_enable  (busy),
        .rollover_val  (c_bit_roll),
        .rollover_flag (w_timer_flag)
    );

    flex_counter #(
        .WIDTH (6)
    ) u_bit_index (
        .clk           (clk),
        .rst           (rst),
        .clear         (w_state_change),
        .count_enable  (w_bit_wrap),
        .rollover_val  (w_idx_roll),
        .rollover_flag (w_idx_flag)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (tx_valid)    w_next_state = SYNC;
            SYNC: if (w_last_wrap) w_next_state = DATA;
            DATA: if (w_last_wrap) w_next_state = (PARITY_EN != 0) ? PAR : IDLE;
            PAR:  if (w_last_wrap) w_next_state = IDLE;
            default:               w_next_state = IDLE;
        endcase
    end

    // serial_out is loaded with the upcoming bit at each bit-period boundary,
    // so the first header bit is already on the line the cycle after accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_hdr      <= '0;
            r_parity   <= 1'b0;
            serial_out <= IDLE_VALUE;
            frame_done <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            frame_done <= (r_state != IDLE) && (w_next_state == IDLE);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shift    <= tx_data;
                        r_parity   <= even_parity(32'(tx_data));
                        r_hdr      <= SYNC_PATTERN[2:0];
                        serial_out <= SYNC_PATTERN[3];
                    end
                end
                SYNC: begin
                    if (w_bit_wrap) begin
                        if (w_idx_flag) begin
                            serial_out <= r_shift[0];
                            r_shift    <= r_shift >> 1;
                        end else begin
                            serial_out <= r_hdr[2];
                            r_hdr      <= r_hdr << 1;
                        end
                    end
                end
                DATA: begin
                    if (w_bit_wrap) begin
                        if (w_idx_flag) begin
                            serial_out <= (PARITY_EN != 0) ? r_parity : IDLE_VALUE;
                        end else begin
                            serial_out <= r_shift[0];
                            r_shift    <= r_shift >> 1;
                        end
                    end
                end
                PAR: begin
                    if (w_bit_wrap) begin
                        serial_out <= IDLE_VALUE;
                    end
                end
                default: serial_out <= IDLE_VALUE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sync_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_frame_tx
// Brief    : Directed frame checks on three parameterisations of sync_frame_tx.
// Revision : 1.0
// ============================================================================
module tb_sync_frame_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] td;
    logic       tv;
    int         sel;

    logic v0, v1, v2;
    logic r0, r1, r2;
    logic s0, s1, s2;
    logic b0, b1, b2;
    logic d0, d1, d2;

    logic ready_m, so_m, busy_m, done_m;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic [12:0] frame;
        int         nbits;
        int         bc;
    } vec_t;

    vec_t vecs [0:6];

    always #5 clk = ~clk;

    assign v0 = tv && (sel == 0);
    assign v1 = tv && (sel == 1);
    assign v2 = tv && (sel == 2);

    sync_frame_tx #(.DATA_BITS(8), .BIT_CYCLES(1), .PARITY_EN(1), .IDLE_VALUE(1'b0)) dut (
        .clk(clk), .rst(rst), .tx_data(td), .tx_valid(v0),
        .tx_ready(r0), .serial_out(s0), .busy(b0), .frame_done(d0));

    sync_frame_tx #(.DATA_BITS(8), .BIT_CYCLES(1), .PARITY_EN(0), .IDLE_VALUE(1'b0)) dut_np (
        .clk(clk), .rst(rst), .tx_data(td), .tx_valid(v1),
        .tx_ready(r1), .serial_out(s1), .busy(b1), .frame_done(d1));

    sync_frame_tx #(.DATA_BITS(8), .BIT_CYCLES(3), .PARITY_EN(1), .IDLE_VALUE(1'b0)) dut_st (
        .clk(clk), .rst(rst), .tx_data(td), .tx_valid(v2),
        .tx_ready(r2), .serial_out(s2), .busy(b2), .frame_done(d2));

    always_comb begin
        ready_m = r0; so_m = s0; busy_m = b0; done_m = d0;
        case (sel)
            1: begin ready_m = r1; so_m = s1; busy_m = b1; done_m = d1; end
            2: begin ready_m = r2; so_m = s2; busy_m = b2; done_m = d2; end
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t sel=%0d)", name, act, exp, $time, sel);
        end
    endtask

    // Walks every bit period of a frame, then the frame_done/idle cycle.
    task automatic check_frame(input logic [12:0] f, input int nb, input int bc,
                               input int poke_at, input string tag);
        int k = 0;
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < bc; c++) begin
                @(negedge clk);
                k++;
                chk({tag, "_bit"},  so_m,   f[12-b]);
                chk({tag, "_busy"}, busy_m, 1'b1);
                chk({tag, "_done"}, done_m, 1'b0);
                if (k == poke_at) begin
                    tv = 1'b1;
                    td = 8'h3C;
                    chk({tag, "_ready_busy"}, ready_m, 1'b0);
                end else if (k == poke_at + 1) begin
                    tv = 1'b0;
                end
            end
        end
        @(negedge clk);
        chk({tag, "_done_pulse"}, done_m, 1'b1);
        chk({tag, "_done_line"},  so_m,   1'b0);
        chk({tag, "_done_ready"}, ready_m, 1'b1);
        chk({tag, "_done_busy"},  busy_m, 1'b0);
    endtask

    task automatic send(input int s, input logic [7:0] d, input logic [12:0] f,
                        input int nb, input int bc, input int poke_at, input string tag);
        @(negedge clk);
        sel = s;
        #1;
        chk({tag, "_ready_pre"}, ready_m, 1'b1);
        td = d;
        tv = 1'b1;
        @(posedge clk);
        #1;
        tv = 1'b0;
        td = ~d;
        check_frame(f, nb, bc, poke_at, tag);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk({tag, "_after_done"}, done_m, 1'b0);
            chk({tag, "_after_busy"}, busy_m, 1'b0);
        end
    endtask

    initial begin
        vecs[0] = '{0, 8'hA5, 13'b1101_10100101_0, 13, 1};
        vecs[1] = '{0, 8'h07, 13'b1101_11100000_1, 13, 1};
        vecs[2] = '{0, 8'h3C, 13'b1101_00111100_0, 13, 1};
        vecs[3] = '{1, 8'h07, 13'b1101_11100000_1, 12, 1};
        vecs[4] = '{1, 8'hA5, 13'b1101_10100101_0, 12, 1};
        vecs[5] = '{2, 8'h01, 13'b1101_10000000_1, 13, 3};
        vecs[6] = '{2, 8'h3C, 13'b1101_00111100_0, 13, 3};

        rst = 1'b1;
        tv  = 1'b0;
        td  = 8'h00;
        sel = 0;
        #1;
        chk("rst_line", so_m,   1'b0);
        chk("rst_busy", busy_m, 1'b0);
        chk("rst_done", done_m, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", ready_m, 1'b1);

        // Reset while idle
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("idle_rst_line", so_m,   1'b0);
        chk("idle_rst_busy", busy_m, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_rst_ready", ready_m, 1'b1);

        // Reset in the middle of the payload: must act without a clock edge
        td = 8'hA5;
        tv = 1'b1;
        @(posedge clk);
        #1;
        tv = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_bit",  so_m,   1'b1);
        chk("pre_rst_busy", busy_m, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_line", so_m,   1'b0);
        chk("mid_rst_busy", busy_m, 1'b0);
        chk("mid_rst_done", done_m, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", ready_m, 1'b1);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("post_rst_line", so_m,   1'b0);
            chk("post_rst_busy", busy_m, 1'b0);
            chk("post_rst_done", done_m, 1'b0);
        end

        for (int i = 0; i < 7; i++) begin
            send(vecs[i].sel, vecs[i].data, vecs[i].frame, vecs[i].nbits, vecs[i].bc,
                 -1, $sformatf("vec%0d", i));
        end

        // New request during the payload must be ignored
        send(0, 8'hA5, 13'b1101_10100101_0, 13, 1, 7, "busy_ignore");

        // Back-to-back with tx_valid held high
        @(negedge clk);
        sel = 0;
        td  = 8'hFF;
        tv  = 1'b1;
        @(posedge clk);
        #1;
        td = 8'h00;
        check_frame(13'b1101_11111111_0, 13, 1, -1, "b2b_first");
        @(posedge clk);
        #1;
        tv = 1'b0;
        td = 8'hAA;
        check_frame(13'b1101_00000000_0, 13, 1, -1, "b2b_second");
        @(negedge clk);
        chk("b2b_end_done", done_m, 1'b0);
        chk("b2b_end_busy", busy_m, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
